// File: rtl/button_step_gen_if.sv
// button_step_gen_if: raw board buttons in, counter step pulses and debounced levels out.
interface button_step_gen_if;
   logic       BTN_W;
   logic       BTN_E;
   logic       STEP_UP;
   logic       STEP_DN;
   logic [1:0] HELD;
   modport master (output BTN_W, BTN_E, input STEP_UP, STEP_DN, HELD);
   modport slave (input BTN_W, BTN_E, output STEP_UP, STEP_DN, HELD);
endinterface

// File: rtl/button_step_gen.sv
// button_step_gen: synchronise/debounce BTN_W/BTN_E into one-cycle STEP_UP/STEP_DN pulses.
// Define AUTO_REPEAT_EN to add hold-to-repeat (REPEAT_DELAY, then every REPEAT_PERIOD).
module button_step_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 16
) (
   input logic              CLK,
   input logic              RST,
   button_step_gen_if.slave bus
);
   localparam int MX = (DEBOUNCE_CYCLES > REPEAT_DELAY)
      ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
      : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam int CW = $clog2(MX + 1);
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW-1:0] DL  = CW'(DEBOUNCE_CYCLES - 1);
   localparam bit D1 = DEBOUNCE_CYCLES == 1;
   typedef enum logic [2:0] {IDLE, ARM, HOLD, RPT, REL} state_t;
   function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction
   logic [1:0] raw, held, held_n, pend, ev, step;
   assign raw = {bus.BTN_W, bus.BTN_E};
   generate
      for (genvar c = 0; c < 2; c++) begin : ch
         logic [1:0]    sy;
         logic          s, acc, fire, go_rpt;
         state_t        st, st_n;
         logic [CW-1:0] cnt, cnt_n;
         assign s = sy[1];
         always_ff @(posedge CLK or negedge RST)
            if (!RST) begin
               sy  <= '0;
               st  <= IDLE;
               cnt <= '0;
            end else begin
               sy  <= {sy[0], raw[c]};
               st  <= st_n;
               cnt <= cnt_n;
            end
         always_comb begin
            st_n  = st;
            cnt_n = cnt;
            acc   = 1'b0;
            case (st)
               IDLE: if (s) begin
                  st_n  = D1 ? HOLD : ARM;
                  cnt_n = ONE;
                  acc   = D1;
               end
               ARM: if (!s) begin
                  st_n  = IDLE;
                  cnt_n = '0;
               end else if (cnt >= DL) begin
                  st_n = HOLD;
                  acc  = 1'b1;
               end else cnt_n = inc(cnt);
               HOLD, RPT: if (!s) begin
                  st_n  = D1 ? IDLE : REL;
                  cnt_n = ONE;
               end else st_n = go_rpt ? RPT : HOLD;
               REL: if (s) st_n = go_rpt ? RPT : HOLD;
                  else if (cnt >= DL) st_n = IDLE;
                  else cnt_n = inc(cnt);
               default: st_n = IDLE;
            endcase
         end
`ifdef AUTO_REPEAT_EN
         localparam logic [CW-1:0] RDL = CW'(REPEAT_DELAY - 1);
         localparam logic [CW-1:0] RPL = CW'(REPEAT_PERIOD - 1);
         logic          rpt, rpt_n;
         logic [CW-1:0] rt, rt_n;
         always_ff @(posedge CLK or negedge RST)
            if (!RST) begin
               rpt <= 1'b0;
               rt  <= '0;
            end else begin
               rpt <= rpt_n;
               rt  <= rt_n;
            end
         // timer advances only while held with the button down, so a release glitch pauses it
         always_comb begin
            rpt_n = rpt;
            rt_n  = rt;
            fire  = 1'b0;
            if (st == IDLE || st == ARM) begin
               rpt_n = 1'b0;
               rt_n  = '0;
            end else if (s) begin
               fire  = rt == (rpt ? RPL : RDL);
               rt_n  = fire ? '0 : inc(rt);
               rpt_n = rpt | fire;
            end
         end
         assign go_rpt = rpt_n;
`else
         assign fire   = 1'b0;
         assign go_rpt = 1'b0;
`endif
         assign held_n[c] = st_n inside {HOLD, RPT, REL};
         assign ev[c]     = acc | (fire & ~&held);
      end
   endgenerate
   // simultaneous events on both channels cancel each other
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         held <= '0;
         pend <= '0;
         step <= '0;
      end else begin
         held <= held_n;
         pend <= ev;
         step <= {pend[1] & ~pend[0], pend[0] & ~pend[1]};
      end
   assign bus.STEP_UP = step[1];
   assign bus.STEP_DN = step[0];
   assign bus.HELD    = held;
endmodule

// File: tb/tb_button_step_gen.sv
// tb_button_step_gen: directed + random stimulus, run-length reference model feeding a pulse scoreboard.
module tb_button_step_gen;
   localparam int DEB = 4, RD = 20, RP = 5;
`ifdef AUTO_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif
   logic CLK = 1'b0;
   logic RST = 1'b0;
   button_step_gen_if bus ();
   button_step_gen #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .CLK(CLK), .RST(RST), .bus(bus));
   always #5 CLK = ~CLK;
   typedef struct {int edge_n; bit up;} pulse_t;
   pulse_t exp_q[$];
   int checks = 0, failures = 0, cyc = 0;
   int n_up = 0, n_dn = 0, last_up = -1, last_dn = -1;
   bit lv[2], r1[2], r2[2];
   int opp[2], rc[2];
   task automatic chk(string nm, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, got, exp, cyc);
      end
   endtask
   task automatic tick(int n);
      repeat (n) @(negedge CLK);
      #1;
   endtask
   // reference model: a level flips after DEB consecutive opposite synchronised samples;
   // repeats fire when the count of held-and-pressed edges reaches RD, RD+RP, ...
   initial forever begin
      @(negedge RST);
      exp_q.delete();
      for (int c = 0; c < 2; c++) begin
         lv[c] = 0; r1[c] = 0; r2[c] = 0; opp[c] = 0; rc[c] = 0;
      end
   end
   initial begin : model
      bit lb[2], ev[2], raw[2];
      bit s, fire;
      pulse_t p;
      forever begin
         @(posedge CLK);
         cyc++;
         if (RST) begin
            raw[1] = bus.BTN_W;
            raw[0] = bus.BTN_E;
            lb = lv;
            for (int c = 0; c < 2; c++) begin
               s = r2[c]; r2[c] = r1[c]; r1[c] = raw[c];
               fire = 0;
               ev[c] = 0;
               if (lb[c] && s) begin
                  rc[c]++;
                  fire = REP_EN && rc[c] >= RD && (rc[c] - RD) % RP == 0;
               end
               opp[c] = (s != lv[c]) ? opp[c] + 1 : 0;
               if (opp[c] == DEB) begin
                  lv[c] = !lv[c]; opp[c] = 0; rc[c] = 0; ev[c] = lv[c];
               end
               ev[c] = ev[c] || (fire && !(lb[0] && lb[1]));
            end
            p.edge_n = cyc + 1;
            if (ev[1] && !ev[0]) begin p.up = 1; exp_q.push_back(p); end
            if (ev[0] && !ev[1]) begin p.up = 0; exp_q.push_back(p); end
         end
      end
   end
   initial begin : monitor
      pulse_t p;
      forever begin
         @(negedge CLK);
         if (RST) begin
            chk("held", bus.HELD, {lv[1], lv[0]});
            if (bus.STEP_UP || bus.STEP_DN) begin
               chk("exclusive", bus.STEP_UP & bus.STEP_DN, 0);
               if (exp_q.size() == 0) chk("unexpected pulse edge", cyc, -1);
               else begin
                  p = exp_q.pop_front();
                  chk("pulse edge", cyc, p.edge_n);
                  chk("pulse is up", bus.STEP_UP, p.up);
               end
               if (bus.STEP_UP) begin n_up++; last_up = cyc; end
               else begin n_dn++; last_dn = cyc; end
            end else if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
               p = exp_q.pop_front();
               chk("missed pulse edge", -1, p.edge_n);
            end
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end
   initial begin : stim
      int n0, n1, k;
      bus.BTN_W = 0;
      bus.BTN_E = 0;
      tick(1);
      bus.BTN_W = 1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("t1 reset step_up", bus.STEP_UP, 0);
         chk("t1 reset held", bus.HELD, 0);
      end
      RST = 1;
      k = cyc;
      n0 = n_up;
      tick(10);
      chk("t1 count", n_up - n0, 1);
      chk("t1 latency", last_up - (k + 1), 6);
      bus.BTN_W = 0;
      tick(12);
      n0 = n_up;
      bus.BTN_W = 1; tick(1);
      bus.BTN_W = 0; tick(1);
      bus.BTN_W = 1; tick(1);
      bus.BTN_W = 0; tick(1);
      bus.BTN_W = 1;
      k = cyc;
      tick(12);
      chk("t2 count", n_up - n0, 1);
      chk("t2 latency", last_up - (k + 1), 6);
      bus.BTN_W = 0;
      tick(12);
      n0 = n_dn;
      bus.BTN_E = 1;
      for (int i = 0; i < 15 && n_dn == n0; i++) tick(1);
      chk("t3 accept", n_dn - n0, 1);
      k = last_dn;
      tick(40);
      chk("t3 pulses", n_dn - n0, REP_EN ? 6 : 1);
      chk("t3 last offset", last_dn - k, REP_EN ? 40 : 0);
      bus.BTN_E = 0;
      tick(15);
      n0 = n_up;
      bus.BTN_W = 1;
      tick(10);
      chk("t4 first", n_up - n0, 1);
      bus.BTN_W = 0; tick(2);
      bus.BTN_W = 1; tick(4);
      chk("t4 glitch held", bus.HELD[1], 1);
      chk("t4 no second", n_up - n0, 1);
      bus.BTN_W = 0; tick(8);
      chk("t4 released", bus.HELD[1], 0);
      bus.BTN_W = 1; tick(10);
      chk("t4 repress", n_up - n0, 2);
      bus.BTN_W = 0;
      tick(12);
      n0 = n_up;
      n1 = n_dn;
      bus.BTN_W = 1;
      bus.BTN_E = 1;
      tick(40);
      chk("t5 conflict up", n_up - n0, 0);
      chk("t5 conflict dn", n_dn - n1, 0);
      chk("t5 both held", bus.HELD, 3);
      bus.BTN_W = 0;
      bus.BTN_E = 0;
      tick(12);
      bus.BTN_W = 1; tick(1);
      bus.BTN_E = 1; tick(12);
      chk("t5 stagger up", n_up - n0, 1);
      chk("t5 stagger dn", n_dn - n1, 1);
      chk("t5 distinct edges", last_up != last_dn, 1);
      bus.BTN_W = 0;
      bus.BTN_E = 0;
      tick(12);
      n0 = n_up;
      bus.BTN_W = 1;
      for (int i = 0; i < 40 && !(bus.STEP_UP && n_up - n0 == (REP_EN ? 2 : 1)); i++) tick(1);
      chk("t6 pulse before reset", bus.STEP_UP, 1);
      #2 RST = 0;
      #1;
      chk("t6 async step_up", bus.STEP_UP, 0);
      chk("t6 async step_dn", bus.STEP_DN, 0);
      chk("t6 async held", bus.HELD, 0);
      bus.BTN_W = 0;
      tick(2);
      RST = 1;
      tick(10);
      chk("t6 idle no pulse", n_up - n0, REP_EN ? 2 : 1);
      chk("t6 idle held", bus.HELD, 0);
      bus.BTN_W = 1;
      tick(10);
      chk("t6 new press", n_up - n0, REP_EN ? 3 : 2);
      bus.BTN_W = 0;
      tick(12);
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 2) == 0) bus.BTN_W = ~bus.BTN_W;
         if ($urandom_range(0, 2) == 0) bus.BTN_E = ~bus.BTN_E;
         if ($urandom_range(0, 60) == 0) begin
            RST = 0;
            tick(1);
            RST = 1;
         end
         tick(int'($urandom_range(1, 12)));
      end
      bus.BTN_W = 0;
      bus.BTN_E = 0;
      tick(30);
      chk("drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
